sum_n_nos_param: RTL and testbench
==================================

// Module: sum_n_nos_param
// PURPOSE
//  Parametrised, mode-selectable successor to the 3-bit sum-of-N unit. Accepts N
//  on a valid/ready request and iterates one term per clock to form a series
//  sum (naturals, squares or odds). Holds the result with sum_valid until the
//  consumer acks. Saturates and flags overflow when the result exceeds SUM_W bits.
// PARAMETERS
//  N_W    3  width of N_in; N range 0..2^N_W-1
//  SUM_W  8  width of sum output (accumulator saturates at 2^SUM_W-1)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  N_valid    in   1      request strobe; N_in/mode sampled when N_valid & ready
//  N_in       in   N_W    N, number of terms
//  mode       in   2      00: sum i; 01: sum i*i; 10: sum (2i-1); 11: same as 00
//  ack        in   1      consumer has taken sum; honoured only while sum_valid
//  ready      out  1      block idle and able to accept a request
//  sum_valid  out  1      sum/overflow valid; held until ack
//  sum        out  SUM_W  result for i=1..N, saturated
//  overflow   out  1      exact result exceeded 2^SUM_W-1 (sum is all-ones)
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE. ready=0 while reset is low. sum_valid=0,
//   sum=0, overflow=0, internal N/count/mode registers cleared. Takes effect
//   immediately in any state and aborts any calculation.
//  ready = (state==IDLE) & reset released. No other output is combinational.
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: on edge with N_valid=1, latch N_in, mode; cnt<=1; acc<=0; overflow<=0.
//     N_in==0 -> DONE directly (sum=0). Otherwise -> CALC.
//   CALC: each edge acc<=sat(acc+term(cnt)); if cnt==N -> DONE, else cnt<=cnt+1.
//     term: mode00 cnt; mode01 cnt*cnt (2*N_W bits); mode10 2*cnt-1.
//   DONE: sum_valid=1, sum=acc. Edge with ack=1 -> IDLE; sum_valid=0 the
//     following cycle. sum/overflow hold their values until the next accept.
//  Latency: N=0 -> sum_valid high 1 cycle after the accept edge. N>=1 ->
//   sum_valid high after N edges following the accept edge. Min. ack-to-ready:
//   1 cycle. The accept edge itself is not counted.
//  Arithmetic: add performed at max(SUM_W,2*N_W+1)+1 bits. If the result exceeds
//   2^SUM_W-1, acc becomes all-ones and overflow sets (sticky for the
//   transaction). Further adds keep acc saturated.
//  Boundaries:
//   - N_valid while ready=0 (CALC/DONE) is ignored; no queuing.
//   - ack outside DONE is ignored.
//   - ack and N_valid in the same DONE cycle: only ack acts. A new request
//     needs ready=1.
//   - N=2^N_W-1: cnt must not wrap. cnt is N_W bits and the terminate compare
//     is equality.
//   - Inputs N_in/mode may change during CALC without effect.
// TESTING
//  1 Reset, then N=0 mode00 -> sum_valid 1 cycle after accept, sum=0,
//    overflow=0. ack -> ready next cycle.
//  2 N=7 mode00 -> sum_valid after 7 cycles, sum=28. Delay ack 5 cycles:
//    sum_valid/sum stable throughout.
//  3 N=7 mode01 -> sum=140, overflow=0. N=7 mode10 -> sum=49. N=4 mode11 -> 10.
//  4 SUM_W=5: N=7 mode01 -> sum=31, overflow=1. Then N=7 mode00 -> sum=28,
//    overflow=0 (flag cleared).
//  5 N=5 mode00, assert reset after 2 CALC cycles -> sum_valid/sum/overflow=0
//    and ready=0 at once. Release, N=3 -> sum=6.
//  6 N_valid with N=2 during CALC and DONE -> ignored. ack in IDLE -> ignored.
//    ack & N_valid same DONE cycle -> IDLE, no new transaction.

Source files
------------

// File: rtl/sum_n_nos_param.sv
// sum_n_nos_param
//   Iterative series-sum unit. A request (N_valid & ready) latches N and a mode;
//   the block then adds one term per clock for i = 1..N and presents the result
//   with sum_valid until the consumer acks. Results wider than SUM_W bits
//   saturate to all-ones and raise overflow for that transaction.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   N_valid    in   1      request strobe, sampled with N_in/mode when ready
//   N_in       in   N_W    number of terms
//   mode       in   2      00: i   01: i*i   10: 2i-1   11: i
//   ack        in   1      result consumed (only acts while sum_valid)
//   ready      out  1      idle and able to accept a request
//   sum_valid  out  1      sum/overflow valid, held until ack
//   sum        out  SUM_W  saturated result
//   overflow   out  1      exact result did not fit in SUM_W bits
module sum_n_nos_param #(
  parameter int N_W   = 3,
  parameter int SUM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             N_valid,
  input  logic [N_W-1:0]   N_in,
  input  logic [1:0]       mode,
  input  logic             ack,
  output logic             ready,
  output logic             sum_valid,
  output logic [SUM_W-1:0] sum,
  output logic             overflow
);

  // Largest term is cnt*cnt (2*N_W bits) or 2*cnt-1 (N_W+1 bits); one extra
  // bit on top of the wider operand keeps the add itself from wrapping.
  localparam int TERM_W = 2 * N_W + 1;
  localparam int ADD_W  = ((SUM_W > TERM_W) ? SUM_W : TERM_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t             state_r;
  logic [N_W-1:0]     n_r;
  logic [N_W-1:0]     cnt_r;
  logic [1:0]         mode_r;
  logic [SUM_W-1:0]   acc_r;
  logic               sum_valid_r;
  logic               overflow_r;

  logic [ADD_W-1:0]   add_s;
  logic [SUM_W-1:0]   sat_s;
  logic               ovf_s;

  // Series term for index c under mode m, widened to the adder width.
  function automatic logic [ADD_W-1:0] term_f(input logic [1:0] m,
                                              input logic [N_W-1:0] c);
    logic [ADD_W-1:0] c_ext;
    c_ext = ADD_W'(c);
    case (m)
      2'b01:   term_f = c_ext * c_ext;
      2'b10:   term_f = (c_ext << 1) - ADD_W'(1);
      2'b00:   term_f = c_ext;
      default: term_f = c_ext;
    endcase
  endfunction

  // Next accumulator value with saturation at 2^SUM_W-1.
  always_comb begin
    add_s = ADD_W'(acc_r) + term_f(mode_r, cnt_r);
    ovf_s = 1'b0;
    sat_s = add_s[SUM_W-1:0];
    if (add_s[ADD_W-1:SUM_W] != '0) begin
      ovf_s = 1'b1;
      sat_s = '1;
    end else begin
      ovf_s = 1'b0;
      sat_s = add_s[SUM_W-1:0];
    end
  end

  // Control FSM and all result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      n_r         <= '0;
      cnt_r       <= '0;
      mode_r      <= 2'b00;
      acc_r       <= '0;
      sum_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (N_valid) begin
            n_r        <= N_in;
            mode_r     <= mode;
            cnt_r      <= N_W'(1);
            acc_r      <= '0;
            overflow_r <= 1'b0;
            if (N_in == '0) begin
              // Empty series: result is ready on the very next cycle.
              state_r     <= ST_DONE;
              sum_valid_r <= 1'b1;
            end else begin
              state_r <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_r <= sat_s;
          if (ovf_s) begin
            overflow_r <= 1'b1;
          end
          // Equality stop keeps cnt from wrapping when N is the maximum value.
          if (cnt_r == n_r) begin
            state_r     <= ST_DONE;
            sum_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + N_W'(1);
          end
        end
        ST_DONE: begin
          // Requests arriving here are dropped; only ack is honoured.
          if (ack) begin
            state_r     <= ST_IDLE;
            sum_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          sum_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // ready drops together with reset, without waiting for a clock.
  assign ready     = (state_r == ST_IDLE) && reset;
  assign sum_valid = sum_valid_r;
  assign sum       = acc_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_sum_n_nos_param.sv
// tb_sum_n_nos_param
//   Drives two instances (SUM_W=8 and SUM_W=5) of sum_n_nos_param through
//   request/ack handshakes. Expected results come from a behavioural series
//   model, are queued when a request is issued and compared when sum_valid
//   rises.
module tb_sum_n_nos_param;

  localparam int N_W     = 3;
  localparam int SUM_W_A = 8;
  localparam int SUM_W_B = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  // Shared stimulus routed to the instance chosen by sel.
  logic           nv  = 1'b0;
  logic           ak  = 1'b0;
  logic           sel = 1'b0;
  logic [N_W-1:0] nin = '0;
  logic [1:0]     md  = 2'b00;

  logic               nv_a, ak_a, nv_b, ak_b;
  logic               ready_a, sv_a, ovf_a;
  logic               ready_b, sv_b, ovf_b;
  logic [SUM_W_A-1:0] sum_a;
  logic [SUM_W_B-1:0] sum_b;

  assign nv_a = sel ? 1'b0 : nv;
  assign ak_a = sel ? 1'b0 : ak;
  assign nv_b = sel ? nv : 1'b0;
  assign ak_b = sel ? ak : 1'b0;

  sum_n_nos_param #(.N_W(N_W), .SUM_W(SUM_W_A)) dut_a (
    .clk(clk), .reset(reset), .N_valid(nv_a), .N_in(nin), .mode(md),
    .ack(ak_a), .ready(ready_a), .sum_valid(sv_a), .sum(sum_a),
    .overflow(ovf_a)
  );

  sum_n_nos_param #(.N_W(N_W), .SUM_W(SUM_W_B)) dut_b (
    .clk(clk), .reset(reset), .N_valid(nv_b), .N_in(nin), .mode(md),
    .ack(ak_b), .ready(ready_b), .sum_valid(sv_b), .sum(sum_b),
    .overflow(ovf_b)
  );

  logic        cur_ready, cur_sv, cur_ovf;
  logic [31:0] cur_sum;

  always_comb begin
    if (sel) begin
      cur_ready = ready_b;
      cur_sv    = sv_b;
      cur_ovf   = ovf_b;
      cur_sum   = 32'(sum_b);
    end else begin
      cur_ready = ready_a;
      cur_sv    = sv_a;
      cur_ovf   = ovf_a;
      cur_sum   = 32'(sum_a);
    end
  end

  typedef struct {
    int unsigned sum;
    bit          ovf;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Exact series sum, then saturation to w bits.
  function automatic exp_t model(input int n, input int m, input int w);
    exp_t        e;
    int unsigned total = 0;
    int unsigned cap   = (32'd1 << w) - 32'd1;
    for (int i = 1; i <= n; i++) begin
      case (m)
        1:       total += i * i;
        2:       total += 2 * i - 1;
        default: total += i;
      endcase
    end
    e.ovf = (total > cap);
    e.sum = e.ovf ? cap : total;
    e.lat = n;  // edges after the accept edge before sum_valid is seen
    return e;
  endfunction

  // One full transaction: request, wait for result, hold, ack.
  task automatic run_txn(input bit s, input int n, input int m, input int hold,
                         input bit noise, input bit ack_with_req);
    exp_t e;
    int   lat;
    sel = s;
    @(negedge clk);
    check_val("ready_before_req", cur_ready, 32'd1);
    nv  = 1'b1;
    nin = N_W'(n);
    md  = 2'(m);
    sb_q.push_back(model(n, m, s ? SUM_W_B : SUM_W_A));
    @(posedge clk);
    #1;
    // Inputs wander after the accept; optional requests must be ignored.
    nv  = noise;
    nin = N_W'(2);
    md  = 2'(m + 1);
    lat = 0;
    while (!cur_sv && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
      e.sum = 0;
      e.ovf = 1'b0;
      e.lat = 0;
    end else begin
      e = sb_q.pop_front();
    end
    check_val("latency", 32'(lat), 32'(e.lat));
    check_val("sum", cur_sum, e.sum);
    check_val("overflow", cur_ovf, 32'(e.ovf));
    check_val("ready_in_done", cur_ready, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_val("sum_valid_held", cur_sv, 32'd1);
      check_val("sum_held", cur_sum, e.sum);
    end
    ak = 1'b1;
    nv = ack_with_req;
    @(posedge clk);
    #1;
    ak = 1'b0;
    nv = 1'b0;
    check_val("sum_valid_after_ack", cur_sv, 32'd0);
    check_val("ready_after_ack", cur_ready, 32'd1);
    check_val("sum_kept_after_ack", cur_sum, e.sum);
    check_val("ovf_kept_after_ack", cur_ovf, 32'(e.ovf));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_ready_a", ready_a, 32'd0);
    check_val("rst_sv_a", sv_a, 32'd0);
    check_val("rst_sum_a", 32'(sum_a), 32'd0);
    check_val("rst_ovf_a", ovf_a, 32'd0);
    check_val("rst_ready_b", ready_b, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_val("ready_after_rst", ready_a, 32'd1);

    // Basic sums and the empty series
    run_txn(1'b0, 0, 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 7, 0, 5, 1'b0, 1'b0);
    run_txn(1'b0, 7, 1, 1, 1'b0, 1'b0);
    run_txn(1'b0, 7, 2, 1, 1'b0, 1'b0);
    run_txn(1'b0, 4, 3, 1, 1'b0, 1'b0);

    // Narrow accumulator: saturation, then the flag clears on the next job
    run_txn(1'b1, 7, 1, 2, 1'b0, 1'b0);
    run_txn(1'b1, 7, 0, 1, 1'b0, 1'b0);
    run_txn(1'b1, 5, 1, 0, 1'b0, 1'b0);
    run_txn(1'b1, 6, 2, 0, 1'b0, 1'b0);

    // ack while idle does nothing
    sel = 1'b0;
    @(negedge clk);
    ak = 1'b1;
    @(negedge clk);
    ak = 1'b0;
    check_val("idle_ack_ready", ready_a, 32'd1);
    check_val("idle_ack_sv", sv_a, 32'd0);

    // Requests during CALC/DONE are ignored
    run_txn(1'b0, 6, 0, 2, 1'b1, 1'b0);
    // ack together with a request in DONE: back to idle, nothing new starts
    run_txn(1'b0, 5, 2, 1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_val("no_txn_after_ack_req", sv_a, 32'd0);
      check_val("idle_after_ack_req", ready_a, 32'd1);
    end

    // Reset in the middle of a calculation
    sel = 1'b0;
    @(negedge clk);
    nv  = 1'b1;
    nin = N_W'(5);
    md  = 2'b00;
    @(posedge clk);
    #1;
    nv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_val("midrst_ready", ready_a, 32'd0);
    check_val("midrst_sv", sv_a, 32'd0);
    check_val("midrst_sum", 32'(sum_a), 32'd0);
    check_val("midrst_ovf", ovf_a, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_txn(1'b0, 3, 0, 0, 1'b0, 1'b0);

    // A few random transactions on both widths
    for (int k = 0; k < 8; k++) begin
      run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
